// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for seg7_scan_ctrl: value/control inputs from the
// register side and the registered pin drive back out to the board.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 3
);
  logic [4*NUM_DIGITS-1:0] x;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_en;
  logic                    blink_en;
  logic [PWM_BITS-1:0]     bright;
  logic [6:0]              a_to_g;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    frame_start;

  // Register/debug side: supplies the value and display controls.
  modport master (
    output x, dp_in, load, blank_en, blink_en, bright,
    input  a_to_g, an, dp, frame_start
  );

  // Display controller side.
  modport slave (
    input  x, dp_in, load, blank_en, blink_en, bright,
    output a_to_g, an, dp, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex 7-segment scanner with frame-synchronous double
// buffering, per-digit decimal points, leading-zero blanking, PWM brightness
// and whole-display blink. All pin outputs are registered.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 32768,
  parameter int PWM_BITS    = 3,
  parameter int BLINK_SCANS = 64
) (
  input  logic             clk,
  input  logic             clr,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  // Each brightness step is REFRESH_DIV >> PWM_BITS cycles wide; as both are
  // powers of two the window limit is a shift of (bright+1).
  localparam int SLOT_SH = PRESC_W - PWM_BITS;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SCANS - 1);
  localparam logic [PRESC_W:0]   ONE_LIMIT  = (PRESC_W+1)'(1);

  // Scan state
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  // Double buffer: pending is written by load, active is what is scanned
  logic [4*NUM_DIGITS-1:0] pend_x_q, pend_x_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_x_q, act_x_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

  // Registered pin drive
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  // Decode helpers
  logic                    presc_tc;
  logic                    frame_wrap;
  logic [3:0]              digit_nib;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [PRESC_W:0]        pwm_limit;
  logic                    in_window;
  logic                    slot_off;

  // Hex to active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001101;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A digit above 0 is a leading zero when it and every higher nibble are
  // zero; digit 0 always shows so a zero value still displays "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = bus.blank_en &&
                               (act_x_q[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  // Prescaler, digit index and blink counter advance.
  always_comb begin
    presc_tc      = (presc_q == PRESC_LAST);
    frame_wrap    = presc_tc && (idx_q == IDX_LAST);
    presc_d       = presc_tc ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (presc_tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Buffer update: a load landing on the wrap cycle bypasses straight into
  // active, so the freshly loaded value is visible in the frame that starts.
  always_comb begin
    pend_x_d  = bus.load ? bus.x     : pend_x_q;
    pend_dp_d = bus.load ? bus.dp_in : pend_dp_q;
    act_x_d   = frame_wrap ? pend_x_d  : act_x_q;
    act_dp_d  = frame_wrap ? pend_dp_d : act_dp_q;
  end

  // Pin drive for the current slot; registered below so the pins trail the
  // scan state by one cycle and two anodes are never low together.
  always_comb begin
    digit_nib     = act_x_q[4*idx_q +: 4];
    pwm_limit     = ((PRESC_W+1)'(bus.bright) + ONE_LIMIT) << SLOT_SH;
    in_window     = ({1'b0, presc_q} < pwm_limit);
    slot_off      = blank_vec[idx_q] || !in_window ||
                    (bus.blink_en && blink_phase_q);
    an_d          = '1;
    if (!slot_off) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d         = seg_decode(digit_nib);
    dp_d          = ~act_dp_q[idx_q];
    frame_start_d = frame_wrap;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_x_q      <= '0;
      pend_dp_q     <= '0;
      act_x_q       <= '0;
      act_dp_q      <= '0;
      seg_q         <= 7'h7F;
      an_q          <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_x_q      <= pend_x_d;
      pend_dp_q     <= pend_dp_d;
      act_x_q       <= act_x_d;
      act_dp_q      <= act_dp_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.a_to_g      = seg_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 8-cycle slots, 2-bit PWM and a
// 2-frame blink half-period. A cycle model predicts every output cycle into a
// scoreboard queue; directed steps add constant checks at the key points.
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model state: cycles since clear, and the two buffers
  int          t = 0;
  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pdp = '0, m_adp = '0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .PWM_BITS(2), .BLINK_SCANS(2)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Predict the pin values that the coming edge will register.
  task automatic model_step();
    exp_t e;
    int idx, presc, frame;
    logic blank, lit, blink_off;
    logic [3:0] nib;
    if (clr) begin
      e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1, fs: 1'b0};
      t = 0;
      m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    end else begin
      idx       = (t / 8) % 4;
      presc     = t % 8;
      frame     = t / 32;
      nib       = 4'((m_act >> (4*idx)) & 16'h000F);
      blank     = bus.blank_en && (idx != 0) && ((m_act >> (4*idx)) == 16'h0);
      lit       = presc < (int'(bus.bright) + 1) * 2;
      blink_off = bus.blink_en && ((frame / 2) % 2 == 1);
      e.an      = (blank || !lit || blink_off) ? 4'hF : ~(4'b0001 << idx);
      e.seg     = seg_tab[nib];
      e.dp      = ~m_adp[idx];
      e.fs      = (t % 32 == 31);
      if (bus.load) begin
        m_pend = bus.x;
        m_pdp  = bus.dp_in;
      end
      if (t % 32 == 31) begin
        m_act = m_pend;
        m_adp = m_pdp;
      end
      t++;
    end
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare, away from the active edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_seg", 32'(bus.a_to_g), 32'(e.seg));
      chk("sb_an", 32'(bus.an), 32'(e.an));
      chk("sb_dp", 32'(bus.dp), 32'(e.dp));
      chk("sb_fs", 32'(bus.frame_start), 32'(e.fs));
      $display("cycle t=%0d seg=%b an=%b dp=%b fs=%b", t, bus.a_to_g, bus.an, bus.dp, bus.frame_start);
    end
  end

  // Stop at the negedge where frame_start is high, bounded.
  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) seen = 1;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL frame_start_timeout got 0 exp 1");
    end
  endtask

  task automatic do_load(input logic [15:0] val, input logic [3:0] dps);
    @(posedge clk);
    #1;
    bus.x = val; bus.dp_in = dps; bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input logic [6:0] seg, input logic [3:0] an, input logic dp);
    chk({tag, "_seg"}, 32'(bus.a_to_g), 32'(seg));
    chk({tag, "_an"}, 32'(bus.an), 32'(an));
    chk({tag, "_dp"}, 32'(bus.dp), 32'(dp));
  endtask

  initial begin
    int cnt;
    clr = 1'b1;
    bus.x = '0; bus.dp_in = '0; bus.load = 1'b0;
    bus.blank_en = 1'b0; bus.blink_en = 1'b0; bus.bright = 2'd3;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_slot("reset", 7'h7F, 4'hF, 1'b1);
    chk("reset_fs", 32'(bus.frame_start), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;

    // Mid-frame load: display must hold until the wrap
    wait_frame();
    repeat (10) @(posedge clk);
    #1;
    bus.x = 16'hA510; bus.dp_in = 4'b0100; bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_frame();
    @(negedge clk);
    chk_slot("a510_d0", 7'b0000001, 4'b1110, 1'b1);
    repeat (8) @(negedge clk);
    chk_slot("a510_d1", 7'b1001111, 4'b1101, 1'b1);
    repeat (8) @(negedge clk);
    chk_slot("a510_d2", 7'b0100100, 4'b1011, 1'b0);
    repeat (8) @(negedge clk);
    chk_slot("a510_d3", 7'b0001000, 4'b0111, 1'b1);

    // Leading-zero blanking
    bus.blank_en = 1'b1;
    do_load(16'h0030, 4'b0000);
    wait_frame();
    @(negedge clk);
    chk_slot("blank_d0", 7'b0000001, 4'b1110, 1'b1);
    repeat (8) @(negedge clk);
    chk_slot("blank_d1", 7'b0000110, 4'b1101, 1'b1);
    repeat (8) @(negedge clk);
    chk("blank_d2_an", 32'(bus.an), 32'hF);
    repeat (8) @(negedge clk);
    chk("blank_d3_an", 32'(bus.an), 32'hF);
    do_load(16'h0000, 4'b0000);
    wait_frame();
    repeat (34) @(negedge clk);

    // PWM duty on slot 0
    bus.blank_en = 1'b0;
    bus.bright = 2'd0;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.an[0] == 1'b0) cnt++;
    end
    chk("pwm_b0_cycles", 32'(cnt), 32'd2);
    bus.bright = 2'd2;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.an[0] == 1'b0) cnt++;
    end
    chk("pwm_b2_cycles", 32'(cnt), 32'd6);

    // Blink: frame_start keeps its 32-cycle cadence
    bus.bright = 2'd3;
    bus.blink_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) cnt++;
    end
    chk("blink_fs_count", 32'(cnt), 32'd4);
    repeat (32) @(negedge clk);
    bus.blink_en = 1'b0;

    // Load on the wrap cycle goes straight to the starting frame
    wait_frame();
    repeat (31) @(posedge clk);
    #1;
    bus.x = 16'h1234; bus.dp_in = 4'b0001; bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
    chk("wrapload_fs", 32'(bus.frame_start), 32'd1);
    @(negedge clk);
    chk_slot("wrapload_d0", 7'b1001100, 4'b1110, 1'b0);

    // Clear mid-slot
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk_slot("midclr", 7'h7F, 4'hF, 1'b1);
    chk("midclr_fs", 32'(bus.frame_start), 32'd0);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
